// File: rtl/dtcm_arbiter_if.sv
// ----------------------------------------------------------------------------
// dtcm_arbiter_if
// Bundles the signals between the data-TCM arbiter, its two requesters (CPU
// load/store port and host loader/debug port) and the single-port DTCM.
//   cpu_*  : CPU request set (req/we/be/addr/wdata in, gnt/rvalid out)
//   host_* : host request set, plus host_lock to keep host priority
//   rdata  : shared read data returned to both requesters
//   mem_*  : DTCM strobe, write enable, byte enables, address, data
//   starve_cnt : current host wait count, exported for tracing
// The slave modport is the arbiter's view; the master modport is the view of
// the logic surrounding it (requesters plus memory).
// ----------------------------------------------------------------------------
interface dtcm_arbiter_if #(
    parameter int AW = 14
);
    logic          cpu_req;
    logic          cpu_we;
    logic [3:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;

    logic          host_req;
    logic          host_we;
    logic [3:0]    host_be;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          host_lock;
    logic          host_gnt;
    logic          host_rvalid;

    logic [31:0]   rdata;

    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [3:0]    starve_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid,
        input  host_req, host_we, host_be, host_addr, host_wdata, host_lock,
        output host_gnt, host_rvalid,
        output rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output starve_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid,
        output host_req, host_we, host_be, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rvalid,
        input  rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  starve_cnt
    );
endinterface

// File: rtl/dtcm_arbiter.sv
// ----------------------------------------------------------------------------
// dtcm_arbiter
// Shares the single-port data TCM between the CPU load/store port and the
// host port. At most one requester is granted per cycle (grant is
// combinational, the access happens that cycle); read data comes back on the
// shared rdata one cycle later, flagged by the issuer's rvalid.
// CPU has default priority. A starvation counter forces the host in after
// STARVE_LIMIT consecutive waiting cycles, and host_lock lets the host keep
// the memory across a burst once it has been granted.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-low
//   bus   : dtcm_arbiter_if slave modport (requesters, memory, trace)
// AW must match the AW of the connected interface instance.
// ----------------------------------------------------------------------------
module dtcm_arbiter #(
    parameter int AW           = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    dtcm_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        PRI_CPU    = 2'd0,
        FORCE_HOST = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_HOST = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        r_state;
    owner_t        r_rd_owner;
    logic [3:0]    r_starve_cnt;

    logic          w_host_pri;
    logic          w_lock_hold;
    logic          w_cpu_gnt;
    logic          w_host_gnt;
    logic [3:0]    w_cnt_nxt;
    owner_t        w_owner_nxt;

    logic          w_mem_we;
    logic [3:0]    w_mem_be;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;

    // LOCKED only keeps host priority while host_lock is high; the cycle it
    // drops, arbitration and transitions already behave as PRI_CPU.
    assign w_lock_hold = (r_state == LOCKED) && bus.host_lock;
    assign w_host_pri  = (r_state == FORCE_HOST) || w_lock_hold;

    // Grants are gated by reset so nothing reaches the memory while it is low.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (reset) begin
            if (w_host_pri) begin
                w_host_gnt = bus.host_req;
            end else begin
                w_cpu_gnt  = bus.cpu_req;
                w_host_gnt = bus.host_req & ~bus.cpu_req;
            end
        end
    end

    always_comb begin
        if (!bus.host_req || w_host_gnt) begin
            w_cnt_nxt = 4'd0;
        end else if (r_starve_cnt != 4'hF) begin
            w_cnt_nxt = r_starve_cnt + 4'd1;
        end else begin
            w_cnt_nxt = r_starve_cnt;
        end
    end

    always_comb begin
        w_owner_nxt = RD_NONE;
        if (w_cpu_gnt && !bus.cpu_we) begin
            w_owner_nxt = RD_CPU;
        end else if (w_host_gnt && !bus.host_we) begin
            w_owner_nxt = RD_HOST;
        end
    end

    // Memory port steering: the winner drives everything, idle drives zeros.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_be    = 4'd0;
        w_mem_addr  = '0;
        w_mem_wdata = 32'd0;
        if (w_cpu_gnt) begin
            w_mem_we    = bus.cpu_we;
            w_mem_be    = bus.cpu_be;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end else if (w_host_gnt) begin
            w_mem_we    = bus.host_we;
            w_mem_be    = bus.host_be;
            w_mem_addr  = bus.host_addr;
            w_mem_wdata = bus.host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PRI_CPU;
            r_starve_cnt <= 4'd0;
            r_rd_owner   <= RD_NONE;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            r_rd_owner   <= w_owner_nxt;
            case (r_state)
                FORCE_HOST: begin
                    if (w_host_gnt) begin
                        r_state <= bus.host_lock ? LOCKED : PRI_CPU;
                    end
                end
                PRI_CPU, LOCKED: begin
                    // A locked host with no request simply keeps its priority.
                    if (w_lock_hold || (w_host_gnt && bus.host_lock)) begin
                        r_state <= LOCKED;
                    end else if (w_cnt_nxt >= LIMIT) begin
                        r_state <= FORCE_HOST;
                    end else begin
                        r_state <= PRI_CPU;
                    end
                end
                default: r_state <= PRI_CPU;
            endcase
        end
    end

    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.cpu_rvalid  = (r_rd_owner == RD_CPU);
    assign bus.host_rvalid = (r_rd_owner == RD_HOST);
    assign bus.rdata       = bus.mem_rdata;
    assign bus.mem_en      = w_cpu_gnt | w_host_gnt;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_be      = w_mem_be;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.starve_cnt  = r_starve_cnt;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dtcm_arbiter
// Drives dtcm_arbiter through directed scenarios and a randomized phase.
// A behavioural model (host-owed / host-locked flags, wait count, shadow
// memory) predicts grants, memory port values, rvalids, read data and the
// starvation count. A simple DTCM model answers the DUT's memory port.
// ----------------------------------------------------------------------------
module tb_dtcm_arbiter;
    localparam int AW    = 14;
    localparam int LIM   = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    dtcm_arbiter_if #(.AW(AW)) bus ();

    dtcm_arbiter #(.AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // DTCM model: byte-masked writes, registered reads.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          m_wait;
    bit          m_owed;
    bit          m_locked;
    int          m_pend;       // 0 none, 1 cpu, 2 host
    logic [31:0] m_pend_data;

    bit ec, eh;                // predicted grants of the last cycle
    bit obs_cg, obs_hg;        // observed grants of the last cycle

    function automatic logic [31:0] init_word(int i);
        if (i == 32'h20) return 32'h12345678;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    function automatic acc_t idle();
        return '0;
    endfunction

    function automatic acc_t rd(int a);
        acc_t x = '0;
        x.req = 1'b1; x.addr = AW'(a); x.be = 4'hF;
        return x;
    endfunction

    function automatic acc_t wr(int a, logic [31:0] d, logic [3:0] be);
        acc_t x = '0;
        x.req = 1'b1; x.we = 1'b1; x.addr = AW'(a); x.wdata = d; x.be = be;
        return x;
    endfunction

    function automatic acc_t rand_acc();
        acc_t x = '0;
        if ($urandom_range(0, 9) < 6) begin
            x.req   = 1'b1;
            x.we    = ($urandom_range(0, 2) == 0);
            x.be    = 4'($urandom);
            x.addr  = AW'($urandom_range(0, 31));
            x.wdata = $urandom;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_owed = 0; m_locked = 0; m_pend = 0;
    endtask

    task automatic drive(input acc_t c, input acc_t h, input bit hl);
        bus.cpu_req    = c.req;  bus.cpu_we    = c.we;   bus.cpu_be   = c.be;
        bus.cpu_addr   = c.addr; bus.cpu_wdata = c.wdata;
        bus.host_req   = h.req;  bus.host_we   = h.we;   bus.host_be  = h.be;
        bus.host_addr  = h.addr; bus.host_wdata = h.wdata;
        bus.host_lock  = hl;
    endtask

    task automatic check_regs();
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_pend == 1));
        check("host_rvalid", 32'(bus.host_rvalid), 32'(m_pend == 2));
        if (m_pend != 0) check("rdata", bus.rdata, m_pend_data);
        check("starve_cnt", 32'(bus.starve_cnt), 32'(m_wait));
    endtask

    task automatic check_comb(input acc_t c, input acc_t h, input bit hl,
                              output bit pc, output bit ph);
        bit   host_first;
        acc_t w;
        host_first = m_owed || (m_locked && hl);
        pc = c.req && !host_first;
        ph = h.req && (host_first || !c.req);
        obs_cg = bus.cpu_gnt;
        obs_hg = bus.host_gnt;
        check("cpu_gnt", 32'(bus.cpu_gnt), 32'(pc));
        check("host_gnt", 32'(bus.host_gnt), 32'(ph));
        check("mem_en", 32'(bus.mem_en), 32'(pc | ph));
        w = pc ? c : (ph ? h : idle());
        check("mem_we", 32'(bus.mem_we), 32'(w.we));
        check("mem_be", 32'(bus.mem_be), 32'(w.be));
        check("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
        check("mem_wdata", bus.mem_wdata, w.wdata);
    endtask

    task automatic apply(input acc_t x, input int who);
        if (x.we) begin
            for (int b = 0; b < 4; b++)
                if (x.be[b]) ref_mem[x.addr][8*b +: 8] = x.wdata[8*b +: 8];
        end else begin
            m_pend      = who;
            m_pend_data = ref_mem[x.addr];
        end
    endtask

    task automatic model_update(input acc_t c, input acc_t h, input bit hl,
                                input bit pc, input bit ph);
        m_pend = 0;
        if (pc) apply(c, 1);
        if (ph) apply(h, 2);
        if (ph) begin
            m_wait = 0; m_owed = 0; m_locked = hl;
        end else begin
            if (!hl) m_locked = 0;
            if (h.req) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            else       m_wait = 0;
            if (m_wait >= LIM) m_owed = 1;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input acc_t c, input acc_t h, input bit hl);
        check_regs();
        drive(c, h, hl);
        #2;
        check_comb(c, h, hl, ec, eh);
        model_update(c, h, hl, ec, eh);
        @(posedge clk); #1;
    endtask

    // Async reset asserted after the grant is visible, before the clock edge.
    task automatic reset_mid(input acc_t c, input acc_t h, input bit hl);
        check_regs();
        drive(c, h, hl);
        #2;
        check_comb(c, h, hl, ec, eh);
        reset = 1'b0;
        #1;
        check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("rst_starve", 32'(bus.starve_cnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        check("rst_host_rvalid_edge", 32'(bus.host_rvalid), 32'd0);
        check("rst_cpu_rvalid_edge", 32'(bus.cpu_rvalid), 32'd0);
        reset = 1'b1;
    endtask

    acc_t cq, hq;
    bit   hl;
    int   exp_starve [6] = '{1, 2, 3, 4, 0, 1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        model_reset();

        // Reset held with both requesters active
        drive(rd(16'h10), rd(16'h11), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("init_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("init_host_gnt", 32'(bus.host_gnt), 32'd0);
        check("init_mem_en", 32'(bus.mem_en), 32'd0);
        check("init_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("init_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("init_starve", 32'(bus.starve_cnt), 32'd0);
        reset = 1'b1;

        // First access after release: CPU read of 0x10
        cycle(rd(16'h10), idle(), 1'b0);
        check("first_cpu_gnt", 32'(obs_cg), 32'd1);
        check("first_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("first_rdata", bus.rdata, init_word(16'h10));
        cycle(idle(), idle(), 1'b0);

        // Contention: CPU 0-3, host 4, CPU 5
        cq = rd(16'h30); hq = rd(16'h40);
        for (int k = 0; k < 6; k++) begin
            cycle(cq, hq, 1'b0);
            check($sformatf("cont_cpu_gnt%0d", k), 32'(obs_cg), 32'(k != 4));
            check($sformatf("cont_host_gnt%0d", k), 32'(obs_hg), 32'(k == 4));
            check($sformatf("cont_starve%0d", k), 32'(bus.starve_cnt), 32'(exp_starve[k]));
            if (ec) cq = rd(16'h31 + k);
            if (eh) hq = rd(16'h41);
        end
        cycle(idle(), idle(), 1'b0);

        // Host byte-masked write then CPU read of the same word
        cycle(idle(), wr(16'h20, 32'hDEADBEEF, 4'b0011), 1'b0);
        cycle(rd(16'h20), idle(), 1'b0);
        check("merge_rdata", bus.rdata, 32'h1234BEEF);
        check("merge_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("merge_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        cycle(idle(), idle(), 1'b0);

        // Lock: host forced in with lock high, keeps 8 more reads, then drops
        cq = rd(16'h100); hq = rd(16'h200);
        for (int k = 0; k < 5; k++) begin
            cycle(cq, hq, 1'b1);
            if (ec) cq = rd(16'h101 + k);
            if (eh) hq = rd(16'h201);
        end
        check("lock_entry_host_gnt", 32'(obs_hg), 32'd1);
        for (int k = 0; k < 8; k++) begin
            cycle(cq, hq, 1'b1);
            check($sformatf("lock_host_gnt%0d", k), 32'(obs_hg), 32'd1);
            check($sformatf("lock_cpu_gnt%0d", k), 32'(obs_cg), 32'd0);
            hq = rd(16'h202 + k);
        end
        cycle(cq, hq, 1'b0);
        check("unlock_cpu_gnt", 32'(obs_cg), 32'd1);
        cycle(idle(), idle(), 1'b0);

        // Interleaved back-to-back reads
        cycle(rd(16'h50), idle(), 1'b0);
        check("ilv0_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        cycle(idle(), rd(16'h51), 1'b0);
        check("ilv1_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        check("ilv1_rdata", bus.rdata, init_word(16'h51));
        cycle(rd(16'h52), idle(), 1'b0);
        check("ilv2_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("ilv2_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        cycle(idle(), idle(), 1'b0);

        // Async reset between a host read grant and its data cycle
        cycle(rd(16'h60), rd(16'h61), 1'b0);
        reset_mid(idle(), rd(16'h61), 1'b0);
        cycle(rd(16'h62), rd(16'h63), 1'b0);
        check("post_rst_cpu_gnt", 32'(obs_cg), 32'd1);

        // Randomized traffic; unserved requests stay stable until granted
        cq = idle(); hq = idle(); hl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!cq.req) cq = rand_acc();
            if (!hq.req) hq = rand_acc();
            if ($urandom_range(0, 7) == 0) hl = ~hl;
            if ($urandom_range(0, 399) == 0) begin
                reset_mid(cq, hq, hl);
                cq = idle(); hq = idle();
            end else begin
                cycle(cq, hq, hl);
                if (ec) cq = rand_acc();
                if (eh) hq = rand_acc();
            end
        end
        cycle(idle(), idle(), 1'b0);
        check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
